// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer states, opcode map and IR field positions.
// Used by the control sequencer and by the datapath.
package cpu_pkg;

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      T0   = 4'd1,
      T1   = 4'd2,
      T2   = 4'd3,
      T3   = 4'd4,
      T4   = 4'd5,
      T5   = 4'd6,
      T6   = 4'd7,
      HALT = 4'd8
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'h00;
   localparam logic [4:0] OP_ROL  = 5'h08;
   localparam logic [4:0] OP_MUL  = 5'h0F;
   localparam logic [4:0] OP_DIV  = 5'h10;
   localparam logic [4:0] OP_NEG  = 5'h11;
   localparam logic [4:0] OP_NOT  = 5'h12;
   localparam logic [4:0] OP_NOP  = 5'h1A;
   localparam logic [4:0] OP_HALT = 5'h1B;

   localparam int IR_OP_LSB = 27;
   localparam int IR_RA_LSB = 23;
   localparam int IR_RB_LSB = 19;
   localparam int IR_RC_LSB = 15;

   typedef enum logic [2:0] {
      CLS_BINARY  = 3'd0,
      CLS_MULDIV  = 3'd1,
      CLS_UNARY   = 3'd2,
      CLS_NOP     = 3'd3,
      CLS_HALT    = 3'd4,
      CLS_ILLEGAL = 3'd5
   } op_class_t;

   // Groups opcodes by the step pattern they need after fetch.
   function automatic op_class_t classify_op(input logic [4:0] op);
      op_class_t cls;
      case (op)
         OP_ADD, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, OP_ROL: cls = CLS_BINARY;
         OP_MUL, OP_DIV:  cls = CLS_MULDIV;
         OP_NEG, OP_NOT:  cls = CLS_UNARY;
         OP_NOP:          cls = CLS_NOP;
         OP_HALT:         cls = CLS_HALT;
         default:         cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Converts a 4-bit register index plus enable into a 16-bit one-hot select.
module reg_select_decoder (
   input  logic [3:0]  idx_i,
   input  logic        en_i,
   output logic [15:0] onehot_o
);

   // One-hot expansion; all-zero when disabled.
   always_comb begin
      onehot_o = 16'h0000;
      if (en_i) begin
         onehot_o[idx_i] = 1'b1;
      end else begin
         onehot_o = 16'h0000;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) then per-opcode execute steps.
// All outputs are Moore decodes of the state register and ir.
module control_sequencer
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic        mem_ready,
   input  logic [31:0] ir,
   output logic [15:0] reg_in,
   output logic [15:0] reg_out,
   output logic        PCout,
   output logic        MARin,
   output logic        pc_increment,
   output logic        read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        RYin,
   output logic        Zhighin,
   output logic        Zlowin,
   output logic        Zhighout,
   output logic        Zlowout,
   output logic        HIin,
   output logic        LOin,
   output logic [4:0]  op_code,
   output logic        busy,
   output logic        halted,
   output logic        illegal
);

   state_t     state_q, state_d;
   logic [4:0] op_s;
   logic [3:0] ra_s, rb_s, rc_s;
   logic [3:0] rout_idx_s;
   logic       rin_en_s, rout_en_s;
   op_class_t  op_cls_s;
   logic       ir_unused_s;

   assign op_s        = ir[IR_OP_LSB +: 5];
   assign ra_s        = ir[IR_RA_LSB +: 4];
   assign rb_s        = ir[IR_RB_LSB +: 4];
   assign rc_s        = ir[IR_RC_LSB +: 4];
   assign op_cls_s    = classify_op(op_s);
   assign ir_unused_s = ^ir[14:0];

   // State register.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      state_d      = state_q;
      PCout        = 1'b0;
      MARin        = 1'b0;
      pc_increment = 1'b0;
      read         = 1'b0;
      MDRin        = 1'b0;
      MDRout       = 1'b0;
      IRin         = 1'b0;
      RYin         = 1'b0;
      Zhighin      = 1'b0;
      Zlowin       = 1'b0;
      Zhighout     = 1'b0;
      Zlowout      = 1'b0;
      HIin         = 1'b0;
      LOin         = 1'b0;
      op_code      = 5'd0;
      rin_en_s     = 1'b0;
      rout_en_s    = 1'b0;
      rout_idx_s   = rb_s;
      busy         = 1'b0;
      halted       = 1'b0;
      illegal      = 1'b0;
      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = T0;
            end else begin
               state_d = IDLE;
            end
         end
         T0: begin
            busy         = 1'b1;
            PCout        = 1'b1;
            MARin        = 1'b1;
            pc_increment = 1'b1;
            state_d      = T1;
         end
         T1: begin
            busy  = 1'b1;
            read  = 1'b1;
            MDRin = 1'b1;
            if (mem_ready) begin
               state_d = T2;
            end else begin
               state_d = T1;
            end
         end
         T2: begin
            busy    = 1'b1;
            MDRout  = 1'b1;
            IRin    = 1'b1;
            state_d = T3;
         end
         T3: begin
            busy = 1'b1;
            case (op_cls_s)
               CLS_BINARY, CLS_MULDIV: begin
                  rout_en_s = 1'b1;
                  RYin      = 1'b1;
                  state_d   = T4;
               end
               CLS_UNARY: begin
                  rout_en_s = 1'b1;
                  op_code   = op_s;
                  Zhighin   = 1'b1;
                  Zlowin    = 1'b1;
                  state_d   = T4;
               end
               CLS_NOP:  state_d = T0;
               CLS_HALT: state_d = HALT;
               default: begin
                  illegal = 1'b1;
                  state_d = T0;
               end
            endcase
         end
         T4: begin
            busy = 1'b1;
            case (op_cls_s)
               CLS_BINARY, CLS_MULDIV: begin
                  rout_en_s  = 1'b1;
                  rout_idx_s = rc_s;
                  op_code    = op_s;
                  Zhighin    = 1'b1;
                  Zlowin     = 1'b1;
                  state_d    = T5;
               end
               CLS_UNARY: begin
                  Zlowout  = 1'b1;
                  rin_en_s = 1'b1;
                  state_d  = T0;
               end
               default: state_d = T0;
            endcase
         end
         T5: begin
            busy = 1'b1;
            case (op_cls_s)
               CLS_BINARY: begin
                  Zlowout  = 1'b1;
                  rin_en_s = 1'b1;
                  state_d  = T0;
               end
               CLS_MULDIV: begin
                  Zlowout = 1'b1;
                  LOin    = 1'b1;
                  state_d = T6;
               end
               default: state_d = T0;
            endcase
         end
         T6: begin
            busy     = 1'b1;
            Zhighout = 1'b1;
            HIin     = 1'b1;
            state_d  = T0;
         end
         HALT: begin
            halted  = 1'b1;
            state_d = HALT;
         end
         default: state_d = IDLE;
      endcase
   end

   reg_select_decoder u_rin_dec (
      .idx_i    (ra_s),
      .en_i     (rin_en_s),
      .onehot_o (reg_in)
   );

   reg_select_decoder u_rout_dec (
      .idx_i    (rout_idx_s),
      .en_i     (rout_en_s),
      .onehot_o (reg_out)
   );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer with hand-written
// sequences for stalls, halt, mid-instruction reset and illegal opcodes.
module tb_control_sequencer;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        run = 1'b0;
   logic        mem_ready = 1'b1;
   logic [31:0] ir = 32'h0;
   logic [15:0] reg_in, reg_out;
   logic        PCout, MARin, pc_increment, read, MDRin, MDRout, IRin, RYin;
   logic        Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin;
   logic [4:0]  op_code;
   logic        busy, halted, illegal;

   int n_checks = 0;
   int n_fail   = 0;
   int steps_n  = 0;

   localparam logic [13:0] S_PCOUT = 14'h2000, S_MARIN = 14'h1000, S_PCINC = 14'h0800;
   localparam logic [13:0] S_READ  = 14'h0400, S_MDRIN = 14'h0200, S_MDROUT = 14'h0100;
   localparam logic [13:0] S_IRIN  = 14'h0080, S_RYIN  = 14'h0040, S_ZHIN = 14'h0020;
   localparam logic [13:0] S_ZLIN  = 14'h0010, S_ZHOUT = 14'h0008, S_ZLOUT = 14'h0004;
   localparam logic [13:0] S_HIIN  = 14'h0002, S_LOIN  = 14'h0001;
   localparam logic [13:0] S_T0 = S_PCOUT | S_MARIN | S_PCINC;
   localparam logic [13:0] S_T1 = S_READ | S_MDRIN;
   localparam logic [13:0] S_T2 = S_MDROUT | S_IRIN;
   localparam logic [2:0]  ST_BUSY = 3'b100, ST_HALT = 3'b010, ST_ILL = 3'b101;

   localparam logic [31:0] IR_ADD = 32'h00918000;  // add R1,R2,R3
   localparam logic [31:0] IR_MUL = 32'h78228000;  // mul R4,R5
   localparam logic [31:0] IR_NEG = 32'h8B380000;  // neg R6,R7
   localparam logic [31:0] IR_NOP = 32'hD0000000;
   localparam logic [31:0] IR_HLT = 32'hD8000000;
   localparam logic [31:0] IR_ILL = 32'hF8000000;  // op 0x1F

   logic [53:0] outs_s;
   assign outs_s = {reg_in, reg_out, op_code,
                    PCout, MARin, pc_increment, read, MDRin, MDRout, IRin, RYin,
                    Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin,
                    busy, halted, illegal};

   typedef struct packed {
      logic        run;
      logic        mr;
      logic [31:0] ir;
      logic [53:0] exp;
   } vec_t;

   vec_t vecs [0:23];

   control_sequencer dut (
      .clk(clk), .clr(clr), .run(run), .mem_ready(mem_ready), .ir(ir),
      .reg_in(reg_in), .reg_out(reg_out),
      .PCout(PCout), .MARin(MARin), .pc_increment(pc_increment), .read(read),
      .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .RYin(RYin),
      .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
      .HIin(HIin), .LOin(LOin), .op_code(op_code),
      .busy(busy), .halted(halted), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [53:0] ex(input logic [15:0] rin, input logic [15:0] rout,
                                      input logic [4:0] op, input logic [13:0] s,
                                      input logic [2:0] st);
      return {rin, rout, op, s, st};
   endfunction

   function automatic vec_t mk(input logic r, input logic m, input logic [31:0] i,
                               input logic [53:0] e);
      vec_t v;
      v.run = r;
      v.mr  = m;
      v.ir  = i;
      v.exp = e;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      steps_n++;
   endtask

   task automatic check(input string name, input logic [53:0] exp);
      n_checks++;
      if (outs_s !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, outs_s, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Per-cycle structural invariants on the register selects and bus sources.
   always @(negedge clk) begin
      if (!clr) begin
         n_checks++;
         if (!$onehot0(reg_in) || !$onehot0(reg_out) ||
             $countones({|reg_out, PCout, MDRout, Zlowout, Zhighout}) > 1) begin
            n_fail++;
            $display("FAIL bus_invariant: reg_in=%h reg_out=%h PCout=%b MDRout=%b Zlowout=%b Zhighout=%b required one-hot selects and single bus source",
                     reg_in, reg_out, PCout, MDRout, Zlowout, Zhighout);
         end
      end
   end

   initial begin
      int start;
      vecs[0]  = mk(1'b0, 1'b1, IR_ADD, ex(16'h0, 16'h0, 5'h00, 14'h0, 3'b000));
      vecs[1]  = mk(1'b1, 1'b1, IR_ADD, ex(16'h0, 16'h0, 5'h00, S_T0, ST_BUSY));
      vecs[2]  = mk(1'b0, 1'b1, IR_ADD, ex(16'h0, 16'h0, 5'h00, S_T1, ST_BUSY));
      vecs[3]  = mk(1'b1, 1'b1, IR_ADD, ex(16'h0, 16'h0, 5'h00, S_T2, ST_BUSY));
      vecs[4]  = mk(1'b0, 1'b1, IR_ADD, ex(16'h0, 16'h0004, 5'h00, S_RYIN, ST_BUSY));
      vecs[5]  = mk(1'b0, 1'b1, IR_ADD, ex(16'h0, 16'h0008, 5'h00, S_ZHIN | S_ZLIN, ST_BUSY));
      vecs[6]  = mk(1'b0, 1'b1, IR_ADD, ex(16'h0002, 16'h0, 5'h00, S_ZLOUT, ST_BUSY));
      vecs[7]  = mk(1'b0, 1'b1, IR_ADD, ex(16'h0, 16'h0, 5'h00, S_T0, ST_BUSY));
      vecs[8]  = mk(1'b0, 1'b1, IR_MUL, ex(16'h0, 16'h0, 5'h00, S_T1, ST_BUSY));
      vecs[9]  = mk(1'b0, 1'b1, IR_MUL, ex(16'h0, 16'h0, 5'h00, S_T2, ST_BUSY));
      vecs[10] = mk(1'b0, 1'b1, IR_MUL, ex(16'h0, 16'h0010, 5'h00, S_RYIN, ST_BUSY));
      vecs[11] = mk(1'b0, 1'b1, IR_MUL, ex(16'h0, 16'h0020, 5'h0F, S_ZHIN | S_ZLIN, ST_BUSY));
      vecs[12] = mk(1'b0, 1'b1, IR_MUL, ex(16'h0, 16'h0, 5'h00, S_ZLOUT | S_LOIN, ST_BUSY));
      vecs[13] = mk(1'b0, 1'b1, IR_MUL, ex(16'h0, 16'h0, 5'h00, S_ZHOUT | S_HIIN, ST_BUSY));
      vecs[14] = mk(1'b0, 1'b1, IR_MUL, ex(16'h0, 16'h0, 5'h00, S_T0, ST_BUSY));
      vecs[15] = mk(1'b0, 1'b1, IR_NEG, ex(16'h0, 16'h0, 5'h00, S_T1, ST_BUSY));
      vecs[16] = mk(1'b0, 1'b1, IR_NEG, ex(16'h0, 16'h0, 5'h00, S_T2, ST_BUSY));
      vecs[17] = mk(1'b0, 1'b1, IR_NEG, ex(16'h0, 16'h0080, 5'h11, S_ZHIN | S_ZLIN, ST_BUSY));
      vecs[18] = mk(1'b0, 1'b1, IR_NEG, ex(16'h0040, 16'h0, 5'h00, S_ZLOUT, ST_BUSY));
      vecs[19] = mk(1'b0, 1'b1, IR_NEG, ex(16'h0, 16'h0, 5'h00, S_T0, ST_BUSY));
      vecs[20] = mk(1'b0, 1'b1, IR_NOP, ex(16'h0, 16'h0, 5'h00, S_T1, ST_BUSY));
      vecs[21] = mk(1'b0, 1'b1, IR_NOP, ex(16'h0, 16'h0, 5'h00, S_T2, ST_BUSY));
      vecs[22] = mk(1'b0, 1'b1, IR_NOP, ex(16'h0, 16'h0, 5'h00, 14'h0, ST_BUSY));
      vecs[23] = mk(1'b0, 1'b1, IR_NOP, ex(16'h0, 16'h0, 5'h00, S_T0, ST_BUSY));

      // Reset held across edges: everything zero.
      #1;
      check("reset_async", ex(16'h0, 16'h0, 5'h00, 14'h0, 3'b000));
      run = 1'b1;
      step();
      check("reset_ignores_run", ex(16'h0, 16'h0, 5'h00, 14'h0, 3'b000));
      run = 1'b0;
      clr = 1'b0;
      step();
      check("idle_after_reset", ex(16'h0, 16'h0, 5'h00, 14'h0, 3'b000));

      for (int i = 0; i < 24; i++) begin
         run       = vecs[i].run;
         mem_ready = vecs[i].mr;
         ir        = vecs[i].ir;
         step();
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // mem_ready stall: three extra T1 cycles, add completes in 9 cycles.
      start     = steps_n;
      ir        = IR_ADD;
      mem_ready = 1'b0;
      step();
      check("stall_t1_enter", ex(16'h0, 16'h0, 5'h00, S_T1, ST_BUSY));
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("stall_t1_hold%0d", k), ex(16'h0, 16'h0, 5'h00, S_T1, ST_BUSY));
      end
      mem_ready = 1'b1;
      step();
      check("stall_t2", ex(16'h0, 16'h0, 5'h00, S_T2, ST_BUSY));
      for (int k = 0; k < 10 && !PCout; k++) begin
         step();
      end
      check_int("stall_length", steps_n - start, 9);

      // Halt: T3 then HALT, run ignored, clr returns to IDLE.
      ir = IR_HLT;
      step();
      step();
      step();
      check("halt_t3", ex(16'h0, 16'h0, 5'h00, 14'h0, ST_BUSY));
      step();
      check("halt_enter", ex(16'h0, 16'h0, 5'h00, 14'h0, ST_HALT));
      for (int k = 0; k < 3; k++) begin
         run = k[0] ? 1'b0 : 1'b1;
         step();
         check($sformatf("halt_hold%0d", k), ex(16'h0, 16'h0, 5'h00, 14'h0, ST_HALT));
      end
      run = 1'b0;
      #2;
      clr = 1'b1;
      #1;
      check("halt_clr_async", ex(16'h0, 16'h0, 5'h00, 14'h0, 3'b000));
      step();
      clr = 1'b0;
      step();
      check("idle_after_halt_clr", ex(16'h0, 16'h0, 5'h00, 14'h0, 3'b000));

      // clr during T4 of an add: outputs drop immediately, no reg_in follows.
      ir  = IR_ADD;
      run = 1'b1;
      step();
      check("clr_t0", ex(16'h0, 16'h0, 5'h00, S_T0, ST_BUSY));
      run = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
      end
      check("clr_pre_t4", ex(16'h0, 16'h0008, 5'h00, S_ZHIN | S_ZLIN, ST_BUSY));
      #2;
      clr = 1'b1;
      #1;
      check("clr_mid_t4", ex(16'h0, 16'h0, 5'h00, 14'h0, 3'b000));
      step();
      clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check($sformatf("clr_no_rin%0d", k), ex(16'h0, 16'h0, 5'h00, 14'h0, 3'b000));
      end

      // Illegal opcode: one-cycle pulse in T3, then straight to T0.
      ir  = IR_ILL;
      run = 1'b1;
      step();
      run = 1'b0;
      step();
      step();
      step();
      check("illegal_t3", ex(16'h0, 16'h0, 5'h00, 14'h0, ST_ILL));
      step();
      check("illegal_then_t0", ex(16'h0, 16'h0, 5'h00, S_T0, ST_BUSY));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-002 SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port run, input, 1, which starts instruction fetch when the block is idle.
REQ-004 SHALL have port mem_ready, input, 1, which indicates that memory read data is valid on data_in.
REQ-005 SHALL have port ir, input, 32, the current IR contents: op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-006 SHALL have port reg_in, output, 16, one-hot R0in..R15in.
REQ-007 SHALL have port reg_out, output, 16, one-hot R0out..R15out.
REQ-008 SHALL have outputs PCout, MARin, pc_increment, read, MDRin, MDRout, IRin, RYin, Zhighin, Zlowin, Zhighout, Zlowout, HIin and LOin, each 1 bit, driving the datapath strobes of the same name.
REQ-009 SHALL have port op_code, output, 5, the ALU operation select.
REQ-010 SHALL have outputs busy, halted and illegal, each 1 bit, reporting status.

Function
REQ-011 SHALL implement states IDLE, T0, T1, T2, T3, T4, T5, T6 and HALT, with all outputs as Moore decodes of the state register and ir.
REQ-012 SHALL move from IDLE to T0 when run=1 and hold in IDLE otherwise.
REQ-013 SHALL assert PCout, MARin and pc_increment in T0, then go to T1.
REQ-014 SHALL assert read and MDRin in T1, hold T1 while mem_ready=0, and go to T2 in the cycle mem_ready=1.
REQ-015 SHALL assert MDRout and IRin in T2, then go to T3; ir is valid from T3 onward.
REQ-016 SHALL treat op 0x00-0x08 (add, sub, and, or, shr, shra, shl, ror, rol) as binary ALU ops:
- T3: reg_out[Rb], RYin.
- T4: reg_out[Rc], op_code=op, Zhighin, Zlowin.
- T5: Zlowout, reg_in[Ra], then return to T0.
REQ-017 SHALL treat op 0x0F (mul) and 0x10 (div) as:
- T3 and T4 as in REQ-016.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin, then return to T0.
REQ-018 SHALL treat op 0x11 (neg) and 0x12 (not) as unary ops:
- T3: reg_out[Rb], op_code=op, Zhighin, Zlowin.
- T4: Zlowout, reg_in[Ra], then return to T0.
REQ-019 SHALL treat op 0x1A (nop) by going from T3 to T0 with no strobes asserted.
REQ-020 SHALL treat op 0x1B (halt) by going from T3 to HALT, which is left only by reset.
REQ-021 SHALL treat any other op as nop and pulse illegal for exactly the T3 cycle.
REQ-022 SHALL drive op_code=0 and all strobes 0 in every state or step not listed above.
REQ-023 SHALL drive reg_in and reg_out either all-zero or exactly one-hot, and SHALL never assert both a reg_out bit and another bus source (PCout, MDRout, Zlowout, Zhighout) in the same cycle.
REQ-024 SHALL drive busy=1 in T0..T6, and halted=1 only in HALT.
REQ-025 SHALL ignore run in all states other than IDLE.
REQ-026 SHALL issue back-to-back instructions with no IDLE cycle in between.
REQ-027 SHALL take 6 cycles per binary op, 7 per mul/div, 5 per unary op and 4 per nop/illegal, each with mem_ready=1, and SHALL add one cycle per mem_ready=0 cycle spent in T1.

Reset
REQ-028 SHALL, while clr=1, asynchronously force state=IDLE and drive every output 0 (reg_in, reg_out, op_code, strobes, busy, halted, illegal), including when clr asserts mid-instruction or in HALT.
REQ-029 SHALL, after clr deasserts, remain in IDLE until run=1.

Structure
REQ-030 SHALL take the state enumeration, the opcode constants and the ir field bit positions from a shared package (cpu_pkg) that the datapath also uses.
REQ-031 SHALL contain one sub-module, reg_select_decoder, which converts a 4-bit register index plus an enable into a 16-bit one-hot vector, instantiated once for reg_in and once for reg_out.

Verification
REQ-032 SHALL cover: reset, run=1 with mem_ready=1 and ir=0x00918000 (add R1,R2,R3) -> T3 reg_out=0x0004 with RYin; T4 reg_out=0x0008, op_code=0, Zlowin; T5 reg_in=0x0002, Zlowout; T0 again at cycle 7.
REQ-033 SHALL cover: ir=0x78228000 (mul R4,R5) -> T3 reg_out=0x0010; T4 reg_out=0x0020 with op_code=0x0F; T5 LOin with Zlowout; T6 HIin with Zhighout; 7 cycles total.
REQ-034 SHALL cover: mem_ready held 0 for 3 cycles in T1 -> read and MDRin stay 1 throughout, T2 is entered on the first mem_ready=1 cycle, and the instruction is 3 cycles longer.
REQ-035 SHALL cover: ir=0xD8000000 (halt) -> HALT entered after T3, halted=1, busy=0, run pulses ignored; clr -> IDLE with halted=0.
REQ-036 SHALL cover: clr asserted during T4 of an add -> all outputs 0 in the same cycle and no reg_in pulse follows; ir op=0x1F -> illegal=1 for one cycle, then T0.
REQ-037 SHALL assert on every cycle that reg_in and reg_out are each zero or one-hot, and that at most one bus source is active.
